fwd_hazard_ctrl: RTL and testbench

- Produces the 2-bit operand-select codes that drive the EX-stage ALU operand MUX4 instances, together with load-use stall and bubble control.
- Tracks destination register, write-enable and load flag through internal ID/EX, EX/MEM and MEM/WB shadow registers.
- Computes the forwarding selects one stage early and registers them, so the selects are valid at the start of EX.
- Sits beside the ID/EX pipeline register; the front end consumes `stall`, the datapath consumes `fwd_a_sel`/`fwd_b_sel`.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 19 +
 rtl/fwd_hazard_ctrl_pipe_tag_reg.sv | 51 +++++
 rtl/fwd_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared operand-select encodings for the EX-stage ALU operand muxes.
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] SEL_RF    = 2'b00;  // register-file value
  localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB writeback value
  // 2'b11 is reserved and never driven.

  // The younger producer (about to be in EX/MEM) always wins over the older one.
  function automatic logic [1:0] pick_sel(input logic hit_young, input logic hit_old);
    if (hit_young) begin
      return SEL_EXMEM;
    end else if (hit_old) begin
      return SEL_MEMWB;
    end
    return SEL_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_pipe_tag_reg.sv
// Pipeline shadow tag: valid, destination register, write-enable and load flag.
module pipe_tag_reg #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              is_load
);

  logic              valid_q;
  logic [REG_AW-1:0] rd_q;
  logic              reg_write_q;
  logic              is_load_q;

  // Clear wipes the whole tag; bubble only drops valid and holds the other fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (clear) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (bubble) begin
      valid_q     <= 1'b0;
    end else begin
      valid_q     <= in_valid;
      rd_q        <= in_rd;
      reg_write_q <= in_reg_write;
      is_load_q   <= in_is_load;
    end
  end

  assign valid     = valid_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign is_load   = is_load_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control beside the ID/EX register.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  logic              idex_valid, idex_reg_write, idex_is_load;
  logic [REG_AW-1:0] idex_rd;
  logic              exmem_valid, exmem_reg_write, exmem_is_load;
  logic [REG_AW-1:0] exmem_rd;
  logic              memwb_valid, memwb_reg_write, memwb_is_load;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_unused;

  logic [1:0]        fwd_a_d, fwd_a_q;
  logic [1:0]        fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0]  stall_count_q;

  logic idex_fwd, exmem_fwd;
  logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;

  // Flush squashes the ID instruction outright; a stall only inserts a bubble.
  pipe_tag_reg #(.REG_AW(REG_AW)) u_idex (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (stall),
    .clear        (flush),
    .in_valid     (id_valid),
    .in_rd        (id_rd),
    .in_reg_write (id_reg_write),
    .in_is_load   (id_is_load),
    .valid        (idex_valid),
    .rd           (idex_rd),
    .reg_write    (idex_reg_write),
    .is_load      (idex_is_load)
  );

  // The instruction in EX when a flush resolves is squashed on its way to MEM.
  pipe_tag_reg #(.REG_AW(REG_AW)) u_exmem (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (flush),
    .clear        (1'b0),
    .in_valid     (idex_valid),
    .in_rd        (idex_rd),
    .in_reg_write (idex_reg_write),
    .in_is_load   (idex_is_load),
    .valid        (exmem_valid),
    .rd           (exmem_rd),
    .reg_write    (exmem_reg_write),
    .is_load      (exmem_is_load)
  );

  pipe_tag_reg #(.REG_AW(REG_AW)) u_memwb (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (1'b0),
    .clear        (1'b0),
    .in_valid     (exmem_valid),
    .in_rd        (exmem_rd),
    .in_reg_write (exmem_reg_write),
    .in_is_load   (exmem_is_load),
    .valid        (memwb_valid),
    .rd           (memwb_rd),
    .reg_write    (memwb_reg_write),
    .is_load      (memwb_is_load)
  );

  // MEM/WB tag is tracked for completeness; forwarding decisions are made a stage early.
  assign memwb_unused = ^{memwb_valid, memwb_rd, memwb_reg_write, memwb_is_load, exmem_is_load};

  // Load-use hazard detection plus next-cycle forwarding selects.
  always_comb begin
    stall     = 1'b0;
    idex_fwd  = idex_valid & idex_reg_write & (idex_rd != '0);
    exmem_fwd = exmem_valid & exmem_reg_write & (exmem_rd != '0);
    hit_ex_a  = id_uses_rs1 & idex_fwd & (idex_rd == id_rs1);
    hit_ex_b  = id_uses_rs2 & idex_fwd & (idex_rd == id_rs2);
    hit_mem_a = id_uses_rs1 & exmem_fwd & (exmem_rd == id_rs1);
    hit_mem_b = id_uses_rs2 & exmem_fwd & (exmem_rd == id_rs2);
    fwd_a_d   = SEL_RF;
    fwd_b_d   = SEL_RF;

    if (id_valid && !flush && idex_valid && idex_is_load && (idex_rd != '0) &&
        ((id_uses_rs1 && (id_rs1 == idex_rd)) || (id_uses_rs2 && (id_rs2 == idex_rd)))) begin
      stall = 1'b1;
    end

    if (id_valid && !flush && !stall) begin
      fwd_a_d = pick_sel(hit_ex_a, hit_mem_a);
      fwd_b_d = pick_sel(hit_ex_b, hit_mem_b);
    end
  end

  // Selects travel with the ID/EX register so they are valid at the start of EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign ex_valid    = idex_valid;
  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0;
  logic       flush = 1'b0;

  logic        stall, ex_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_count;

  logic        stall2, ex_valid2;
  logic [1:0]  fwd_a_sel2, fwd_b_sel2;
  logic [1:0]  stall_count2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush), .stall(stall2),
    .ex_valid(ex_valid2), .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2),
    .stall_count(stall_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = 1'b1; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_uses_rs1 = 1'b0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    n_vec++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL reset_sels got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
    n_vec++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", stall_count); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);  // add x5, x1, x2
    tick();
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);  // add x6, x5, x1
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall got %b want 0", stall); end
    tick();
    idle();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL b2b_fwd_a got %b want 01", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL b2b_fwd_b got %b want 00", fwd_b_sel); end
    n_vec++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ex_valid got %b want 1", ex_valid); end
  endtask

  task automatic test_distance2();
    reset_dut();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);  // writes x7
    tick();
    issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);  // independent
    tick();
    issue(5'd1, 1'b1, 5'd7, 1'b1, 5'd10, 1'b1, 1'b0); // reads x7 on rs2
    tick();
    idle();
    n_vec++; if (fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL dist2_fwd_b got %b want 10", fwd_b_sel); end
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL dist2_fwd_a got %b want 00", fwd_a_sel); end
  endtask

  task automatic test_load_use();
    reset_dut();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);  // lw x3
    tick();
    issue(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);  // add x4, x3, x3
    n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    n_vec++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL lu_bubble_sels got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once got %b want 0", stall); end
    tick();
    idle();
    n_vec++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL lu_reissue_valid got %b want 1", ex_valid); end
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin n_bad++; $display("FAIL lu_reissue_sels got %b want 1010", {fwd_a_sel, fwd_b_sel}); end
    n_vec++; if (stall_count !== 32'd1) begin n_bad++; $display("FAIL lu_count got %0d want 1", stall_count); end
  endtask

  task automatic test_priority_x0();
    reset_dut();
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0);
    tick();
    issue(5'd9, 1'b1, 5'd9, 1'b1, 5'd11, 1'b0, 1'b0);
    tick();
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin n_bad++; $display("FAIL prio_sels got %b want 0101", {fwd_a_sel, fwd_b_sel}); end
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);  // writes x0
    tick();
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0); // reads x0
    tick();
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL x0_sels got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0); // writes x10
    tick();
    issue(5'd10, 1'b0, 5'd10, 1'b1, 5'd13, 1'b0, 1'b0); // rs1 unused
    tick();
    idle();
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin n_bad++; $display("FAIL unused_rs1 got %b want 0001", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_flush();
    reset_dut();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);  // lw x3
    tick();
    issue(5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall); end
    tick();
    flush = 1'b0;
    n_vec++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ex_valid got %b want 0", ex_valid); end
    n_vec++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", stall_count); end
    // Squashed load must not be forwarded from EX/MEM.
    issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    idle();
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL flush_squash_fwd got %b want 00", fwd_a_sel); end
  endtask

  task automatic load_use_pair();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    issue(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    load_use_pair();
    issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick();
    issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    n_vec++; if (stall !== 1'b1 || stall_count !== 32'd1) begin n_bad++; $display("FAIL pre_reset got stall=%b count=%0d want 1/1", stall, stall_count); end
    rst_n = 1'b0;
    #2;
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL async_stall got %b want 0", stall); end
    n_vec++; if (ex_valid !== 1'b0 || {fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_bad++; $display("FAIL async_state got ev=%b sels=%b want 0/0000", ex_valid, {fwd_a_sel, fwd_b_sel}); end
    n_vec++; if (stall_count !== 32'd0) begin n_bad++; $display("FAIL async_count got %0d want 0", stall_count); end
    idle();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      load_use_pair();
    end
    idle();
    n_vec++; if (stall_count2 !== 2'd3) begin n_bad++; $display("FAIL sat_count got %0d want 3", stall_count2); end
    n_vec++; if (stall_count !== 32'd4) begin n_bad++; $display("FAIL wide_count got %0d want 4", stall_count); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_priority_x0();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
